lspc_timer: RTL

LSPC_TIMER -- requirements
Module: lspc_timer

---
 rtl/lspc_timer.sv | 74 +++++++
 1 files changed

// File: rtl/lspc_timer.sv
// LSPC programmable raster timer: a down-counter clocked by the pixel enable, with
// reloads on CPU write, vblank and zero, and a one-cycle interrupt pulse on each zero event.
module lspc_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLK_EN,
  input  logic             WR_TIMER_HIGH,
  input  logic             WR_TIMER_LOW,
  input  logic             WR_MODE,
  input  logic [15:0]      DIN,
  input  logic             VBLANK_START,
  input  logic             TIMER_STOP,
  output logic             TIMER_IRQ,
  output logic             TIMER_IRQ_EN,
  output logic [CNT_W-1:0] TIMER_CNT
);

  localparam int unsigned HiW = CNT_W - 16;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload_q;
  logic [HiW-1:0]   reload_hi_d;
  logic [15:0]      reload_lo_d;
  logic             en_q, rl_wr_q, rl_vbl_q, rl_zero_q;
  logic             irq_q;
  logic             count_ok;
  logic             zero_evt;

  always_comb begin
    count_ok    = CLK_EN & en_q & ~TIMER_STOP;
    zero_evt    = count_ok & (cnt_q == '0);
    reload_hi_d = WR_TIMER_HIGH ? DIN[HiW-1:0] : reload_q[CNT_W-1:16];
    reload_lo_d = WR_TIMER_LOW ? DIN : reload_q[15:0];

    // Write reload sees the high half as written this cycle; other reloads use the stored value.
    cnt_d = cnt_q;
    if (WR_TIMER_LOW && rl_wr_q) begin
      cnt_d = {reload_hi_d, DIN};
    end else if (VBLANK_START && rl_vbl_q) begin
      cnt_d = reload_q;
    end else if (zero_evt) begin
      cnt_d = rl_zero_q ? reload_q : '1;
    end else if (count_ok) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q     <= '0;
      reload_q  <= '0;
      en_q      <= 1'b0;
      rl_wr_q   <= 1'b0;
      rl_vbl_q  <= 1'b0;
      rl_zero_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= {reload_hi_d, reload_lo_d};
      if (WR_MODE) begin
        {rl_zero_q, rl_vbl_q, rl_wr_q, en_q} <= DIN[7:4];
      end
      // The interrupt fires on every zero event, even when a reload wins the counter.
      irq_q <= zero_evt;
    end
  end

  assign TIMER_IRQ    = irq_q;
  assign TIMER_IRQ_EN = en_q;
  assign TIMER_CNT    = cnt_q;

endmodule
